// File: rtl/issue_pkg.sv
// Shared types for the dual-pipe issue queue: instruction class and the
// decoded bundle that flows from decode through the queue to the pipes.
package issue_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_BR   = 2'd1,
        CLS_MEM  = 2'd2,
        CLS_RSVD = 2'd3
    } issue_cls_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rf_we;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      shift;
        logic [3:0]      alu_op;
        logic            mem_rd;
        logic            mem_wr;
        issue_cls_e      cls;
    } issue_entry_t;

    // Younger instruction reads a register the older one writes (x0 never counts).
    function automatic logic raw_hazard(input issue_entry_t older, input issue_entry_t younger);
        return older.rf_we && (older.rd != 5'd0) &&
               ((older.rd == younger.rs1) || (older.rd == younger.rs2));
    endfunction

endpackage

// File: rtl/issue_pair_select.sv
// Combinational steering for the two oldest queue entries: decides which of
// them issue this cycle and routes each onto the branch or memory pipe.
module issue_pair_select
    import issue_pkg::*;
(
    input  issue_entry_t h0,
    input  issue_entry_t h1,
    input  logic         h0_valid,
    input  logic         h1_valid,
    input  logic         br_stall,
    input  logic         mem_stall,
    output logic         br_issue,
    output logic         mem_issue,
    output issue_entry_t br_entry,
    output issue_entry_t mem_entry,
    output logic         br_older,
    output logic [1:0]   n_issue
);

    logic h0_to_mem;
    logic h0_go;
    logic h1_fits;
    logic h1_go;

    // H0 goes to its own pipe; H1 may only take the pipe H0 leaves free.
    always_comb begin
        h0_to_mem = (h0.cls == CLS_MEM);
        h0_go     = h0_valid && (h0_to_mem ? !mem_stall : !br_stall);

        if (h0_to_mem) begin
            h1_fits = ((h1.cls == CLS_ALU) || (h1.cls == CLS_BR)) && !br_stall;
        end else begin
            h1_fits = ((h1.cls == CLS_ALU) || (h1.cls == CLS_MEM)) && !mem_stall;
        end

        h1_go = h0_go && h1_valid && h1_fits && !raw_hazard(h0, h1);

        br_issue  = (h0_go && !h0_to_mem) || (h1_go && h0_to_mem);
        mem_issue = (h0_go && h0_to_mem) || (h1_go && !h0_to_mem);

        br_entry  = '0;
        mem_entry = '0;
        if (br_issue) begin
            br_entry = h0_to_mem ? h1 : h0;
        end
        if (mem_issue) begin
            mem_entry = h0_to_mem ? h0 : h1;
        end

        br_older = h0_go && h1_go && !h0_to_mem;
        n_issue  = {1'b0, h0_go} + {1'b0, h1_go};
    end

endmodule

// File: rtl/issue_queue.sv
// In-order circular issue queue feeding a branch pipe and a memory pipe,
// accepting up to two decoded instructions and issuing up to two per cycle.
module issue_queue
    import issue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    input  issue_entry_t [1:0]     in_entry,
    output logic                   in_ready,
    input  logic                   br_stall,
    input  logic                   mem_stall,
    output logic                   br_issue,
    output logic                   mem_issue,
    output issue_entry_t           br_entry,
    output issue_entry_t           mem_entry,
    output logic                   br_older,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // The bundle layout is fixed by the package; a mismatched WIDTH keeps
    // the queue refusing input instead of silently truncating fields.
    localparam bit WIDTH_OK = (WIDTH == XLEN);

    issue_entry_t     mem_q [DEPTH];
    issue_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [1:0]       n_enq;
    logic [1:0]       n_issue;
    logic             h0_valid, h1_valid;

    // Readiness and head presence come from the cycle-start occupancy only.
    always_comb begin
        head_p1  = head_q + PTR_W'(1);
        tail_p1  = tail_q + PTR_W'(1);
        in_ready = WIDTH_OK && (count_q <= CNT_W'(DEPTH - 2));
        h0_valid = !flush && (count_q >= CNT_W'(1));
        h1_valid = !flush && (count_q >= CNT_W'(2));
        count    = count_q;
    end

    issue_pair_select u_pair_select (
        .h0        (mem_q[head_q]),
        .h1        (mem_q[head_p1]),
        .h0_valid  (h0_valid),
        .h1_valid  (h1_valid),
        .br_stall  (br_stall),
        .mem_stall (mem_stall),
        .br_issue  (br_issue),
        .mem_issue (mem_issue),
        .br_entry  (br_entry),
        .mem_entry (mem_entry),
        .br_older  (br_older),
        .n_issue   (n_issue)
    );

    // Compacted enqueue at the tail, retire issued entries at the head; flush wins.
    always_comb begin
        mem_d  = mem_q;
        n_enq  = 2'd0;
        if (in_ready && !flush) begin
            if (in_valid[0]) begin
                mem_d[tail_q] = in_entry[0];
                if (in_valid[1]) begin
                    mem_d[tail_p1] = in_entry[1];
                    n_enq = 2'd2;
                end else begin
                    n_enq = 2'd1;
                end
            end else if (in_valid[1]) begin
                mem_d[tail_q] = in_entry[1];
                n_enq = 2'd1;
            end
        end
        head_d  = head_q + PTR_W'(n_issue);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_issue);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer/occupancy registers clear on reset; storage needs no reset since count gates it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH=4): dual issue,
// steering, RAW pairing, stalls, full/wrap behaviour, flush and reset.
module tb_issue_queue;
    import issue_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic [1:0]         in_valid;
    issue_entry_t [1:0] in_entry;
    logic               in_ready;
    logic               br_stall, mem_stall;
    logic               br_issue, mem_issue;
    issue_entry_t       br_entry, mem_entry;
    logic               br_older;
    logic [2:0]         count;

    int compared   = 0;
    int mismatched = 0;

    issue_entry_t z = '0;

    issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_entry  (in_entry),
        .in_ready  (in_ready),
        .br_stall  (br_stall),
        .mem_stall (mem_stall),
        .br_issue  (br_issue),
        .mem_issue (mem_issue),
        .br_entry  (br_entry),
        .mem_entry (mem_entry),
        .br_older  (br_older),
        .count     (count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net in case the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic issue_entry_t mk(input issue_cls_e cls, input logic [31:0] pc,
                                        input logic [4:0] rd, input logic we,
                                        input logic [4:0] rs1);
        issue_entry_t e;
        e         = '0;
        e.cls     = cls;
        e.pc      = pc;
        e.rd      = rd;
        e.rf_we   = we;
        e.rs1     = rs1;
        e.imm     = pc ^ 32'h0000_00FF;
        e.rs1_val = pc + 32'd1;
        e.mem_rd  = (cls == CLS_MEM);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input issue_entry_t e0,
                                 input issue_entry_t e1, input logic bs,
                                 input logic ms, input logic fl);
        in_valid    = v;
        in_entry[0] = e0;
        in_entry[1] = e1;
        br_stall    = bs;
        mem_stall   = ms;
        flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectIssue(input string tag, input logic bi, input logic [31:0] bpc,
                               input logic mi, input logic [31:0] mpc, input logic older);
        checkOutput({tag, ".br_issue"}, 64'(br_issue), 64'(bi));
        if (bi) checkOutput({tag, ".br_pc"}, 64'(br_entry.pc), 64'(bpc));
        else    checkOutput({tag, ".br_zero"}, 64'(|br_entry), 64'd0);
        checkOutput({tag, ".mem_issue"}, 64'(mem_issue), 64'(mi));
        if (mi) checkOutput({tag, ".mem_pc"}, 64'(mem_entry.pc), 64'(mpc));
        else    checkOutput({tag, ".mem_zero"}, 64'(|mem_entry), 64'd0);
        checkOutput({tag, ".br_older"}, 64'(br_older), 64'(older));
    endtask

    task automatic idle();
        applyStimulus(2'b00, z, z, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        checkOutput("rst.count", 64'(count), 64'd0);
        checkOutput("rst.in_ready", 64'(in_ready), 64'd1);
        expectIssue("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // ALU + MEM dual issue, branch pipe older
        applyStimulus(2'b11, mk(CLS_ALU, 32'h100, 0, 0, 0), mk(CLS_MEM, 32'h104, 0, 0, 0), 0, 0, 0);
        checkOutput("a.pre_issue", 64'(br_issue | mem_issue), 64'd0);
        tick(); idle();
        checkOutput("a.count", 64'(count), 64'd2);
        expectIssue("a", 1, 32'h100, 1, 32'h104, 1);
        tick();
        checkOutput("a.count_after", 64'(count), 64'd0);
        expectIssue("a.empty", 0, 0, 0, 0, 0);

        // MEM + MEM serialises on the mem pipe
        applyStimulus(2'b11, mk(CLS_MEM, 32'h200, 0, 0, 0), mk(CLS_MEM, 32'h204, 0, 0, 0), 0, 0, 0);
        tick(); idle();
        expectIssue("b1", 0, 0, 1, 32'h200, 0);
        tick();
        checkOutput("b.count", 64'(count), 64'd1);
        expectIssue("b2", 0, 0, 1, 32'h204, 0);
        tick();
        expectIssue("b.empty", 0, 0, 0, 0, 0);

        // RAW on rd=5 splits the pair
        applyStimulus(2'b11, mk(CLS_ALU, 32'h300, 5, 1, 0), mk(CLS_ALU, 32'h304, 0, 0, 5), 0, 0, 0);
        tick(); idle();
        expectIssue("c1", 1, 32'h300, 0, 0, 0);
        tick();
        expectIssue("c2", 1, 32'h304, 0, 0, 0);
        tick();

        // rd=0 is never a hazard
        applyStimulus(2'b11, mk(CLS_ALU, 32'h310, 0, 1, 0), mk(CLS_ALU, 32'h314, 0, 0, 0), 0, 0, 0);
        tick(); idle();
        expectIssue("c0", 1, 32'h310, 1, 32'h314, 1);
        tick();

        // MEM older than BR: dual issue with mem pipe older
        applyStimulus(2'b11, mk(CLS_MEM, 32'h810, 0, 0, 0), mk(CLS_BR, 32'h814, 0, 0, 0), 0, 0, 0);
        tick(); idle();
        expectIssue("d", 1, 32'h814, 1, 32'h810, 0);
        tick();

        // Stalls: H0 blocked stops everything; blocked free pipe limits to single issue
        applyStimulus(2'b11, mk(CLS_MEM, 32'h700, 0, 0, 0), mk(CLS_ALU, 32'h704, 0, 0, 0), 0, 0, 0);
        tick();
        applyStimulus(2'b00, z, z, 0, 1, 0);
        expectIssue("e.memstall", 0, 0, 0, 0, 0);
        applyStimulus(2'b00, z, z, 1, 0, 0);
        expectIssue("e.brstall", 0, 0, 1, 32'h700, 0);
        tick();
        checkOutput("e.count", 64'(count), 64'd1);
        expectIssue("e.hold", 0, 0, 0, 0, 0);
        idle();
        expectIssue("e.release", 1, 32'h704, 0, 0, 0);
        tick();

        // Fill to full under br_stall, refuse while full, drain with wrap-around
        applyStimulus(2'b11, mk(CLS_ALU, 32'h400, 0, 0, 0), mk(CLS_ALU, 32'h404, 0, 0, 0), 1, 0, 0);
        tick();
        applyStimulus(2'b11, mk(CLS_ALU, 32'h408, 0, 0, 0), mk(CLS_ALU, 32'h40C, 0, 0, 0), 1, 0, 0);
        checkOutput("f.count2", 64'(count), 64'd2);
        checkOutput("f.ready2", 64'(in_ready), 64'd1);
        expectIssue("f.stall", 0, 0, 0, 0, 0);
        tick();
        applyStimulus(2'b11, mk(CLS_ALU, 32'h410, 0, 0, 0), mk(CLS_ALU, 32'h414, 0, 0, 0), 1, 0, 0);
        checkOutput("f.count4", 64'(count), 64'd4);
        checkOutput("f.ready4", 64'(in_ready), 64'd0);
        tick();
        checkOutput("f.refused", 64'(count), 64'd4);
        applyStimulus(2'b11, mk(CLS_ALU, 32'h410, 0, 0, 0), mk(CLS_ALU, 32'h414, 0, 0, 0), 0, 0, 0);
        checkOutput("f.full_ready", 64'(in_ready), 64'd0);
        expectIssue("f.drain1", 1, 32'h400, 1, 32'h404, 1);
        tick();
        checkOutput("f.full_refused", 64'(count), 64'd2);
        checkOutput("f.ready_again", 64'(in_ready), 64'd1);
        expectIssue("f.drain2", 1, 32'h408, 1, 32'h40C, 1);
        tick();
        applyStimulus(2'b10, z, mk(CLS_ALU, 32'h418, 0, 0, 0), 1, 0, 0);
        checkOutput("f.wrap_count", 64'(count), 64'd2);
        tick();
        idle();
        checkOutput("f.count3", 64'(count), 64'd3);
        checkOutput("f.ready3", 64'(in_ready), 64'd0);
        expectIssue("f.wrap", 1, 32'h410, 1, 32'h414, 1);
        tick();
        checkOutput("f.count1", 64'(count), 64'd1);
        expectIssue("f.slot1", 1, 32'h418, 0, 0, 0);
        tick();
        checkOutput("f.count0", 64'(count), 64'd0);

        // Flush beats issue and same-cycle enqueue
        applyStimulus(2'b11, mk(CLS_ALU, 32'h500, 0, 0, 0), mk(CLS_ALU, 32'h504, 0, 0, 0), 1, 0, 0);
        tick();
        applyStimulus(2'b01, mk(CLS_ALU, 32'h508, 0, 0, 0), z, 1, 0, 0);
        tick();
        applyStimulus(2'b11, mk(CLS_ALU, 32'h510, 0, 0, 0), mk(CLS_MEM, 32'h514, 0, 0, 0), 0, 0, 1);
        checkOutput("g.count3", 64'(count), 64'd3);
        expectIssue("g.flush", 0, 0, 0, 0, 0);
        tick(); idle();
        checkOutput("g.count0", 64'(count), 64'd0);
        expectIssue("g.after", 0, 0, 0, 0, 0);
        tick();
        expectIssue("g.stale", 0, 0, 0, 0, 0);

        // Reset wins over a same-cycle enqueue
        applyStimulus(2'b01, mk(CLS_BR, 32'h600, 0, 0, 0), z, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        checkOutput("h.count", 64'(count), 64'd0);
        checkOutput("h.ready", 64'(in_ready), 64'd1);
        expectIssue("h", 0, 0, 0, 0, 0);
        tick();
        checkOutput("h.count_next", 64'(count), 64'd0);
        expectIssue("h.next", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
